// File: rtl/ysyx_23060077_wbu_pkg.sv
// Shared widths, starve limit and writeback payload type for the writeback unit.
`ifndef YSYX_23060077_REG_WIDTH
`define YSYX_23060077_REG_WIDTH 5
`endif
`ifndef YSYX_23060077_DATA_WIDTH
`define YSYX_23060077_DATA_WIDTH 32
`endif
`ifndef YSYX_23060077_WB_STARVE_MAX
`define YSYX_23060077_WB_STARVE_MAX 4
`endif

package ysyx_23060077_wbu_pkg;

    localparam int unsigned ADDR_W     = `YSYX_23060077_REG_WIDTH;
    localparam int unsigned DATA_W     = `YSYX_23060077_DATA_WIDTH;
    localparam int unsigned STARVE_MAX = `YSYX_23060077_WB_STARVE_MAX;
    localparam int unsigned STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam int unsigned NREG       = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_EXU  = 2'd1,
        GNT_LSU  = 2'd2
    } wb_grant_e;

    // EXU has lost enough consecutive arbitrations to be forced through.
    function automatic logic starve_hit(input logic [STARVE_W-1:0] cnt);
        return cnt == STARVE_W'(STARVE_MAX);
    endfunction

endpackage

// File: rtl/ysyx_23060077_scoreboard.sv
// Per-register pending-write scoreboard with rs1/rs2 hazard lookup.
module ysyx_23060077_scoreboard
    import ysyx_23060077_wbu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              busy_any
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // WAW issue must be stalled upstream.
    always_ff @(posedge clock) begin
        if (!reset && set_en && (set_idx != '0)) begin
            assert (!busy_q[set_idx]);
        end
    end

    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];
    assign busy_any = |busy_q;

endmodule

// File: rtl/ysyx_23060077_wbu.sv
// Writeback unit: arbitrates EXU/LSU results onto the single register-file write port
// and tracks pending writes for IDU hazard detection.
module ysyx_23060077_wbu
    import ysyx_23060077_wbu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              exu_valid,
    output logic              exu_ready,
    input  logic [ADDR_W-1:0] exu_rd,
    input  logic [DATA_W-1:0] exu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_rd_addr,
    output logic [DATA_W-1:0] reg_rd_data,
    output logic              wb_busy_any
);

    wb_req_t             exu_req;
    wb_req_t             lsu_req;
    wb_req_t             win_req;
    wb_grant_e           grant;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                en_q;
    logic                en_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_d;

    assign exu_req = '{rd: exu_rd, data: exu_data};
    assign lsu_req = '{rd: lsu_rd, data: lsu_data};

    // LSU priority with EXU starvation override; nothing is accepted while in reset.
    always_comb begin
        grant     = GNT_NONE;
        exu_ready = 1'b0;
        lsu_ready = 1'b0;
        win_req   = lsu_req;
        starve_d  = starve_q;
        en_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;

        if (!reset) begin
            if (lsu_valid && !(exu_valid && starve_hit(starve_q))) begin
                grant = GNT_LSU;
            end else if (exu_valid) begin
                grant = GNT_EXU;
            end
        end

        case (grant)
            GNT_EXU: begin
                exu_ready = 1'b1;
                win_req   = exu_req;
            end
            GNT_LSU: begin
                lsu_ready = 1'b1;
                win_req   = lsu_req;
            end
            default: ;
        endcase

        if (grant == GNT_EXU) begin
            starve_d = '0;
        end else if (exu_valid && !starve_hit(starve_q)) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        // x0 writes are consumed but never reach the register file.
        if (grant != GNT_NONE) begin
            en_d   = (win_req.rd != '0);
            addr_d = win_req.rd;
            data_d = win_req.data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign reg_rd_en   = en_q;
    assign reg_rd_addr = addr_q;
    assign reg_rd_data = data_q;

    ysyx_23060077_scoreboard u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (issue_valid),
        .set_idx  (issue_rd),
        .clr_en   (en_q),
        .clr_idx  (addr_q),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .busy_any (wb_busy_any)
    );

endmodule

// File: tb/tb_ysyx_23060077_wbu.sv
// Directed self-checking bench for the writeback unit.
module tb_ysyx_23060077_wbu;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        reg_rd_en;
    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        wb_busy_any;

    int tests = 0;
    int fails = 0;

    ysyx_23060077_wbu dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .exu_valid   (exu_valid),
        .exu_ready   (exu_ready),
        .exu_rd      (exu_rd),
        .exu_data    (exu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .wb_busy_any (wb_busy_any)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic        exp_lsu;
        logic [31:0] exp_data;

        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
        exu_valid   = 1'b0;
        exu_rd      = 5'd0;
        exu_data    = 32'h0;
        lsu_valid   = 1'b0;
        lsu_rd      = 5'd0;
        lsu_data    = 32'h0;

        #1;
        chk("reset_en",   32'(reg_rd_en),   32'h0);
        chk("reset_addr", 32'(reg_rd_addr), 32'h0);
        chk("reset_data", reg_rd_data,      32'h0);
        chk("reset_busy", 32'(wb_busy_any), 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // EXU only, rd=5
        exu_valid = 1'b1;
        exu_rd    = 5'd5;
        exu_data  = 32'hDEAD_BEEF;
        #1;
        chk("exu_only_exu_ready", 32'(exu_ready), 32'h1);
        chk("exu_only_lsu_ready", 32'(lsu_ready), 32'h0);
        tick();
        exu_valid = 1'b0;
        chk("exu_only_en",   32'(reg_rd_en),   32'h1);
        chk("exu_only_addr", 32'(reg_rd_addr), 32'd5);
        chk("exu_only_data", reg_rd_data,      32'hDEAD_BEEF);
        tick();
        chk("idle_en",        32'(reg_rd_en),   32'h0);
        chk("idle_addr_hold", 32'(reg_rd_addr), 32'd5);
        chk("idle_data_hold", reg_rd_data,      32'hDEAD_BEEF);

        // Both valid for six cycles: LSU,LSU,LSU,LSU,EXU,LSU
        exu_valid = 1'b1;
        exu_rd    = 5'd10;
        exu_data  = 32'hE000_0000;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd11;
        lsu_data  = 32'h1100_0000;
        for (int i = 0; i < 6; i++) begin
            exp_lsu  = (i != 4);
            exp_data = exp_lsu ? lsu_data : exu_data;
            #1;
            chk($sformatf("arb%0d_lsu_ready", i), 32'(lsu_ready), 32'(exp_lsu));
            chk($sformatf("arb%0d_exu_ready", i), 32'(exu_ready), 32'(!exp_lsu));
            tick();
            chk($sformatf("arb%0d_addr", i), 32'(reg_rd_addr), exp_lsu ? 32'd11 : 32'd10);
            chk($sformatf("arb%0d_data", i), reg_rd_data, exp_data);
            if (exp_lsu) begin
                lsu_data = lsu_data + 32'd1;
            end else begin
                exu_data = 32'hE000_0001;
            end
        end
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
        tick();

        // Scoreboard set by issue, cleared one cycle after the write is presented
        rs1_addr = 5'd7;
        rs2_addr = 5'd0;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        chk("sb7_pre_issue", 32'(rs1_busy), 32'h0);
        tick();
        issue_valid = 1'b0;
        chk("sb7_busy",     32'(rs1_busy),    32'h1);
        chk("sb7_any",      32'(wb_busy_any), 32'h1);
        chk("sb7_rs2_zero", 32'(rs2_busy),    32'h0);
        lsu_valid = 1'b1;
        lsu_rd    = 5'd7;
        lsu_data  = 32'h0000_0077;
        #1;
        chk("sb7_lsu_ready", 32'(lsu_ready), 32'h1);
        tick();
        lsu_valid = 1'b0;
        chk("sb7_wr_en",      32'(reg_rd_en),   32'h1);
        chk("sb7_wr_addr",    32'(reg_rd_addr), 32'd7);
        chk("sb7_wr_data",    reg_rd_data,      32'h0000_0077);
        chk("sb7_busy_n1",    32'(rs1_busy),    32'h1);
        tick();
        chk("sb7_busy_n2",    32'(rs1_busy),    32'h0);
        chk("sb7_any_clear",  32'(wb_busy_any), 32'h0);

        // Same-cycle issue of rd=9 while a write to 9 is on the port: set wins
        rs2_addr  = 5'd9;
        exu_valid = 1'b1;
        exu_rd    = 5'd9;
        exu_data  = 32'h0000_0099;
        tick();
        exu_valid   = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        chk("sb9_wr_en", 32'(reg_rd_en),   32'h1);
        chk("sb9_wr_addr", 32'(reg_rd_addr), 32'd9);
        tick();
        issue_valid = 1'b0;
        chk("sb9_set_wins", 32'(rs2_busy), 32'h1);
        lsu_valid = 1'b1;
        lsu_rd    = 5'd9;
        lsu_data  = 32'h0000_0999;
        tick();
        lsu_valid = 1'b0;
        tick();
        chk("sb9_cleared", 32'(rs2_busy), 32'h0);

        // x0 destination: accepted but never written, never busy
        rs1_addr  = 5'd0;
        exu_valid = 1'b1;
        exu_rd    = 5'd0;
        exu_data  = 32'h0000_1234;
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        #1;
        chk("x0_exu_ready", 32'(exu_ready), 32'h1);
        tick();
        exu_valid   = 1'b0;
        issue_valid = 1'b0;
        chk("x0_no_en",  32'(reg_rd_en),   32'h0);
        chk("x0_busy",   32'(rs1_busy),    32'h0);
        chk("x0_any",    32'(wb_busy_any), 32'h0);

        // Async reset mid-cycle with a write on the port and another LSU result pending
        rs1_addr    = 5'd12;
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        tick();
        issue_valid = 1'b0;
        chk("rst_pre_busy", 32'(rs1_busy), 32'h1);
        lsu_valid = 1'b1;
        lsu_rd    = 5'd12;
        lsu_data  = 32'h0000_00CC;
        tick();
        lsu_rd   = 5'd13;
        lsu_data = 32'h0000_00DD;
        chk("rst_pre_en", 32'(reg_rd_en), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_en",    32'(reg_rd_en),   32'h0);
        chk("rst_mid_addr",  32'(reg_rd_addr), 32'h0);
        chk("rst_mid_data",  reg_rd_data,      32'h0);
        chk("rst_mid_busy",  32'(rs1_busy),    32'h0);
        chk("rst_mid_any",   32'(wb_busy_any), 32'h0);
        chk("rst_mid_ready", 32'(lsu_ready),   32'h0);
        lsu_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_after_en1", 32'(reg_rd_en), 32'h0);
        tick();
        chk("rst_after_en2",   32'(reg_rd_en),   32'h0);
        chk("rst_after_addr",  32'(reg_rd_addr), 32'h0);
        chk("rst_after_data",  reg_rd_data,      32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
